seqdet_frame_capture: RTL and testbench
=======================================

Name: seqdet_frame_capture

Overview:
- Downstream stage of the 1101 Moore overlapping sync detector.
- On each detector pulse it deserialises the next DATA_W bits of the same serial stream into a parallel word.
- It presents the word on a single-entry valid/ready output register and counts frames dropped under back-pressure.
- Sits between the bit-serial detector and the byte-oriented consumer logic.

Parameters:
- DATA_W, 8: payload bits captured per detection; legal range 2..32.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- i_data  input  1  serial bit stream, the same stream fed to the detector.
- i_det  input  1  detector Moore output; high for one cycle after 1101 is seen.
- i_ready  input  1  consumer ready.
- o_data  output  DATA_W  captured payload, first received bit in the MSB.
- o_valid  output  1  o_data holds an unconsumed word.
- o_busy  output  1  high while collecting payload bits.
- o_drop_cnt  output  CNT_W  frames completed but discarded; saturating.

Behaviour:
- Reset values:
  - state=HUNT; shift register, bit counter, o_data, o_valid, o_drop_cnt all 0; o_busy=0.
  - Reset mid-collection discards the partial word and any held word.
- Alignment: i_det is high in the cycle where i_data carries payload bit 0, because the Moore output lags the last sync bit by one cycle. Bit 0 is therefore sampled in the same cycle as i_det.
- States:
  - HUNT:
    - i_det=1: sreg <= {sreg[DATA_W-2:0], i_data}, bit_cnt <= 1, go to COLLECT.
    - Otherwise stay in HUNT.
  - COLLECT:
    - Every cycle: sreg <= {sreg[DATA_W-2:0], i_data}, bit_cnt++.
    - When bit_cnt == DATA_W-1, the current bit is the last one; the word {sreg[DATA_W-2:0], i_data} completes, bit_cnt <= 0, go to HUNT.
    - i_det is ignored throughout COLLECT, including in the last-bit cycle, because the payload may itself contain 1101.
- o_busy = (state == COLLECT).
- Latency: i_det at cycle T means bits are sampled at T..T+DATA_W-1, and o_valid rises at T+DATA_W. The earliest next capture starts at T+DATA_W.
- Output register, evaluated in the completion cycle:
  - Load if o_valid==0 or (o_valid && i_ready): o_data <= word, o_valid <= 1.
  - Otherwise the new word is dropped: o_drop_cnt++, saturating at 2^CNT_W-1. o_data and o_valid are unchanged.
- Handshake:
  - Transfer occurs when o_valid && i_ready.
  - Without a simultaneous load, o_valid <= 0 after the transfer.
  - o_data is stable while o_valid=1 and i_ready=0.
  - i_ready may toggle freely; i_ready while o_valid=0 has no effect.
- Simultaneous transfer and load in one cycle: the old word is consumed, the new word is loaded, o_valid stays 1, and there is no drop.
- No combinational path from any input to any output; all outputs are registered or derived from state.

Test Plan:
- DATA_W=8, i_ready=1; i_det=1 at cycle 0; i_data=1,0,1,0,0,1,1,0 on cycles 0..7 -> o_busy high on cycles 1..7; o_valid=1 on cycle 8 only, with o_data=8'hA6; o_drop_cnt=0.
- Payload 1,1,0,1,1,1,0,1 with i_det pulsing mid-payload -> exactly one word, 8'hDD; no restart; o_valid asserts at T+8.
- i_ready=0; two complete frames, A6 then 3C -> o_data holds 8'hA6 with o_valid=1 and o_drop_cnt=1. Then raise i_ready=1 -> one transfer of 8'hA6, after which o_valid=0.
- Held word 8'hA6 with i_ready=1 in the completion cycle of frame 8'h5A -> o_valid stays 1, o_data=8'h5A next cycle, o_drop_cnt unchanged.
- Reset asserted after 4 payload bits -> next cycle o_busy=0, o_valid=0, o_drop_cnt=0. A new i_det followed by 8'hF0 yields o_data=8'hF0 with no residue.
- CNT_W=2, i_ready=0, 6 frames -> the first word is held, 5 are dropped, and o_drop_cnt saturates at 3.

Source files
------------

// File: rtl/seqdet_frame_capture_if.sv
// Serial-in / parallel-out bundle between the sync detector, the frame capture stage and its consumer.
interface seqdet_frame_capture_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
);
    logic              i_data;
    logic              i_det;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              o_busy;
    logic [CNT_W-1:0]  o_drop_cnt;

    modport master (
        input  i_data, i_det, i_ready,
        output o_data, o_valid, o_busy, o_drop_cnt
    );

    modport slave (
        output i_data, i_det, i_ready,
        input  o_data, o_valid, o_busy, o_drop_cnt
    );
endinterface

// File: rtl/seqdet_frame_capture.sv
// Deserialises DATA_W payload bits after each 1101 detector pulse into a single-entry
// valid/ready output register, counting frames lost to back-pressure.
module seqdet_frame_capture #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    seqdet_frame_capture_if.master  bus
);
    localparam int unsigned BCNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam int unsigned SREG_W = DATA_W - 1;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } state_e;

    state_e              state_q,   state_d;
    logic [SREG_W-1:0]   sreg_q,    sreg_d;
    logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   data_q,    data_d;
    logic                valid_q,   valid_d;
    logic [CNT_W-1:0]    drop_q,    drop_d;

    logic [DATA_W-1:0]   word_c;
    logic                done_c;

    // The word is always the held bits plus the bit on the wire this cycle.
    assign word_c = {sreg_q, bus.i_data};

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        drop_d    = drop_q;
        done_c    = 1'b0;

        // i_det only matters while hunting: payload bits may themselves contain 1101.
        case (state_q)
            HUNT: begin
                if (bus.i_det) begin
                    sreg_d    = word_c[SREG_W-1:0];
                    bit_cnt_d = BCNT_W'(1);
                    state_d   = COLLECT;
                end
            end
            COLLECT: begin
                sreg_d = word_c[SREG_W-1:0];
                if (bit_cnt_q == BCNT_W'(DATA_W - 1)) begin
                    bit_cnt_d = '0;
                    state_d   = HUNT;
                    done_c    = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                end
            end
            default: state_d = HUNT;
        endcase

        // A completing word may replace one being consumed in the same cycle.
        if (done_c) begin
            if (!valid_q || bus.i_ready) begin
                data_d  = word_c;
                valid_d = 1'b1;
            end else if (drop_q != {CNT_W{1'b1}}) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end else if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HUNT;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            drop_q    <= drop_d;
        end
    end

    assign bus.o_data     = data_q;
    assign bus.o_valid    = valid_q;
    assign bus.o_busy     = (state_q == COLLECT);
    assign bus.o_drop_cnt = drop_q;
endmodule

// File: tb/tb_seqdet_frame_capture.sv
// Bench for seqdet_frame_capture: a wide-counter and a 2-bit-counter instance share one
// stimulus stream and are compared every cycle against a queue-based frame model.
module tb_seqdet_frame_capture;
    localparam int unsigned DW = 8;

    logic clk;
    logic s_data, s_det, s_rdy, s_reset;
    logic chk_en;
    int   checks, failures;

    seqdet_frame_capture_if #(.DATA_W(DW), .CNT_W(8)) if8 ();
    seqdet_frame_capture_if #(.DATA_W(DW), .CNT_W(2)) if2 ();

    assign if8.i_data  = s_data;
    assign if8.i_det   = s_det;
    assign if8.i_ready = s_rdy;
    assign if2.i_data  = s_data;
    assign if2.i_det   = s_det;
    assign if2.i_ready = s_rdy;

    seqdet_frame_capture #(.DATA_W(DW), .CNT_W(8)) dut8 (.clk(clk), .reset(s_reset), .bus(if8.master));
    seqdet_frame_capture #(.DATA_W(DW), .CNT_W(2)) dut2 (.clk(clk), .reset(s_reset), .bus(if2.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is the DW bits starting at an accepted detection.
    logic       mq[$];
    logic [7:0] m_data;
    logic       m_valid, m_busy;
    int         m_drop8, m_drop2;

    initial begin
        m_data = '0; m_valid = 1'b0; m_busy = 1'b0; m_drop8 = 0; m_drop2 = 0;
    end

    always @(posedge clk) begin
        logic       done;
        logic [7:0] w;
        done = 1'b0;
        w    = '0;
        if (s_reset) begin
            mq.delete();
            m_data = '0; m_valid = 1'b0; m_drop8 = 0; m_drop2 = 0;
        end else begin
            if (mq.size() > 0 || s_det) begin
                mq.push_back(s_data);
                if (mq.size() == DW) begin
                    for (int i = 0; i < DW; i++) w[DW-1-i] = mq[i];
                    mq.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || s_rdy) begin
                    m_data  = w;
                    m_valid = 1'b1;
                end else begin
                    if (m_drop8 < 255) m_drop8++;
                    if (m_drop2 < 3)   m_drop2++;
                end
            end else if (m_valid && s_rdy) begin
                m_valid = 1'b0;
            end
        end
        m_busy = (mq.size() > 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid8", 32'(if8.o_valid), 32'(m_valid));
            chk("busy8",  32'(if8.o_busy),  32'(m_busy));
            chk("drop8",  32'(if8.o_drop_cnt), 32'(m_drop8));
            chk("valid2", 32'(if2.o_valid), 32'(m_valid));
            chk("busy2",  32'(if2.o_busy),  32'(m_busy));
            chk("drop2",  32'(if2.o_drop_cnt), 32'(m_drop2));
            if (m_valid) begin
                chk("data8", 32'(if8.o_data), 32'(m_data));
                chk("data2", 32'(if2.o_data), 32'(m_data));
            end
        end
    end

    // Apply one cycle of inputs; returns at the following negedge.
    task automatic cyc_in(input logic d, input logic det, input logic rdy, input logic rst);
        s_data = d; s_det = det; s_rdy = rdy; s_reset = rst;
        @(negedge clk);
    endtask

    // Bit i of the frame is w[7-i]; det/rdy masks are indexed the same way.
    task automatic send_frame(input logic [7:0] w, input logic [7:0] det_m, input logic [7:0] rdy_m);
        for (int i = 0; i < 8; i++) cyc_in(w[7-i], det_m[7-i], rdy_m[7-i], 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0; chk_en = 1'b0;
        s_data = 1'b0; s_det = 1'b0; s_rdy = 1'b0; s_reset = 1'b1;
        @(negedge clk);
        cyc_in(1'b0, 1'b0, 1'b0, 1'b1);
        cyc_in(1'b0, 1'b0, 1'b0, 1'b1);
        chk_en = 1'b1;
        chk("rst_valid", 32'(if8.o_valid), 32'h0);
        chk("rst_busy",  32'(if8.o_busy),  32'h0);
        chk("rst_data",  32'(if8.o_data),  32'h0);
        chk("rst_drop",  32'(if8.o_drop_cnt), 32'h0);

        // Basic frame A6 with latency T+8.
        cyc_in(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t1_busy_c1", 32'(if8.o_busy), 32'h1);
        for (int i = 1; i < 7; i++) cyc_in(i == 2 || i == 5 || i == 6, 1'b0, 1'b1, 1'b0);
        chk("t1_valid_c7", 32'(if8.o_valid), 32'h0);
        chk("t1_busy_c7",  32'(if8.o_busy),  32'h1);
        cyc_in(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_valid_c8", 32'(if8.o_valid), 32'h1);
        chk("t1_data",     32'(if8.o_data),  32'hA6);
        chk("t1_busy_c8",  32'(if8.o_busy),  32'h0);
        cyc_in(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_valid_c9", 32'(if8.o_valid), 32'h0);

        // Detector pulses inside the payload are ignored.
        send_frame(8'hDD, 8'h91, 8'hFF);
        chk("t2_data",  32'(if8.o_data),  32'hDD);
        chk("t2_valid", 32'(if8.o_valid), 32'h1);
        chk("t2_busy",  32'(if8.o_busy),  32'h0);
        cyc_in(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t2_norestart", 32'(if8.o_busy), 32'h0);

        // Back-pressure: second frame dropped, then drained.
        send_frame(8'hA6, 8'h80, 8'h00);
        send_frame(8'h3C, 8'h80, 8'h00);
        chk("t3_data",  32'(if8.o_data),  32'hA6);
        chk("t3_drop",  32'(if8.o_drop_cnt), 32'h1);
        cyc_in(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_drain", 32'(if8.o_valid), 32'h0);

        // Transfer and load in the same cycle.
        send_frame(8'hA6, 8'h80, 8'h00);
        send_frame(8'h5A, 8'h80, 8'h01);
        chk("t4_data",  32'(if8.o_data),  32'h5A);
        chk("t4_valid", 32'(if8.o_valid), 32'h1);
        chk("t4_drop",  32'(if8.o_drop_cnt), 32'h1);

        // Reset mid-collection clears everything.
        cyc_in(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc_in(1'b1, 1'b0, 1'b0, 1'b0);
        cyc_in(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_busy",  32'(if8.o_busy),  32'h0);
        chk("t5_valid", 32'(if8.o_valid), 32'h0);
        chk("t5_drop",  32'(if8.o_drop_cnt), 32'h0);
        send_frame(8'hF0, 8'h80, 8'hFF);
        chk("t5_data",  32'(if8.o_data),  32'hF0);
        cyc_in(1'b0, 1'b0, 1'b1, 1'b0);

        // Six frames under stall: 2-bit counter saturates.
        send_frame(8'h11, 8'h80, 8'h00);
        for (int f = 0; f < 5; f++) send_frame(8'($urandom), 8'h80, 8'h00);
        chk("t6_data",  32'(if2.o_data),  32'h11);
        chk("t6_drop2", 32'(if2.o_drop_cnt), 32'h3);
        chk("t6_drop8", 32'(if8.o_drop_cnt), 32'h5);
        cyc_in(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t6_drain", 32'(if2.o_valid), 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++)
            cyc_in(1'($urandom), $urandom_range(0, 5) == 0, 1'($urandom),
                   $urandom_range(0, 299) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
